// File: rtl/tpu_host_seq.sv
// Host-side bus initiator for the memory-mapped TPU: streams A/B/C rows in,
// fires one start command, waits out the systolic pass and streams C back out.
module tpu_host_seq #(
   parameter int unsigned BITS_AB   = 8,
   parameter int unsigned BITS_C    = 16,
   parameter int unsigned DIM       = 8,
   parameter int unsigned ADDRW     = 16,
   parameter int unsigned DATAW     = 64,
   parameter int unsigned MM_CYCLES = 3 * DIM
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic             load_c,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATAW-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATAW-1:0] out_data,
   output logic             busy,
   output logic             done,
   output logic [ADDRW-1:0] bus_addr,
   output logic             bus_r_w,
   output logic [DATAW-1:0] bus_wdata,
   input  logic [DATAW-1:0] bus_rdata
);

   localparam int unsigned AB_STEP = (BITS_AB * DIM) / 8;   // bytes per A/B row
   localparam int unsigned C_STEP  = (BITS_C * DIM) / 16;   // bytes per C half-row
   localparam int unsigned WAITW   = $clog2(MM_CYCLES + 1);

   localparam logic [ADDRW-1:0] A_BASE     = ADDRW'('h0100);
   localparam logic [ADDRW-1:0] B_BASE     = ADDRW'('h0200);
   localparam logic [ADDRW-1:0] C_BASE     = ADDRW'('h0300);
   localparam logic [ADDRW-1:0] START_ADDR = ADDRW'('h0400);
   localparam logic [WAITW-1:0] WAIT_LAST  = WAITW'(MM_CYCLES - 2);

   typedef enum logic [2:0] {
      IDLE, WR_A, WR_B, WR_C, START, WAIT, RD_C, DONE
   } state_t;

   state_t           state, next_state;
   logic [3:0]       index;
   logic [WAITW-1:0] wait_cnt;
   logic             load_c_q;
   logic             step;
   logic             last_ab, last_c;
   logic [ADDRW-1:0] ab_off, c_off;

   assign last_ab = (index == 4'(DIM - 1));
   assign last_c  = (index == 4'(2 * DIM - 1));
   assign ab_off  = ADDRW'(index) * ADDRW'(AB_STEP);
   assign c_off   = ADDRW'(index) * ADDRW'(C_STEP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         index    <= '0;
         wait_cnt <= '0;
         load_c_q <= 1'b0;
      end else begin
         state <= next_state;
         if (next_state != state)
            index <= '0;
         else if (step)
            index <= index + 4'd1;
         if (state == WAIT && next_state == WAIT)
            wait_cnt <= wait_cnt + WAITW'(1);
         else
            wait_cnt <= '0;
         if (state == IDLE && go)
            load_c_q <= load_c;
      end
   end

   always_comb begin
      next_state = state;
      step       = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      done       = 1'b0;
      busy       = (state != IDLE);
      bus_addr   = '0;
      bus_r_w    = 1'b0;
      bus_wdata  = '0;
      case (state)
         IDLE: begin
            if (go)
               next_state = WR_A;
         end
         WR_A, WR_B: begin
            in_ready  = 1'b1;
            bus_addr  = ((state == WR_A) ? A_BASE : B_BASE) + ab_off;
            bus_r_w   = in_valid;
            bus_wdata = in_data;
            step      = in_valid;
            if (in_valid && last_ab)
               next_state = (state == WR_A) ? WR_B : WR_C;
         end
         WR_C: begin
            bus_addr = C_BASE + c_off;
            // Without a C stream the half-rows are zero-filled one per cycle.
            if (load_c_q) begin
               in_ready  = 1'b1;
               bus_r_w   = in_valid;
               bus_wdata = in_data;
               step      = in_valid;
            end else begin
               bus_r_w = 1'b1;
               step    = 1'b1;
            end
            if (step && last_c)
               next_state = START;
         end
         START: begin
            bus_addr   = START_ADDR;
            bus_r_w    = 1'b1;
            next_state = WAIT;
         end
         WAIT: begin
            if (wait_cnt == WAIT_LAST)
               next_state = RD_C;
         end
         RD_C: begin
            bus_addr  = C_BASE + c_off;
            out_valid = 1'b1;
            out_data  = bus_rdata;
            step      = out_ready;
            if (out_ready && last_c)
               next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_tpu_host_seq.sv
// Directed bench for tpu_host_seq with a behavioural 8x8 TPU slave on the bus.
module tb_tpu_host_seq;

   localparam int unsigned DATAW = 64;
   localparam int unsigned ADDRW = 16;

   logic             clk = 1'b0;
   logic             rst, go, load_c, in_valid, in_ready, out_valid, out_ready;
   logic             busy, done, bus_r_w;
   logic [DATAW-1:0] in_data, out_data, bus_wdata, bus_rdata;
   logic [ADDRW-1:0] bus_addr;

   int total = 0;
   int bad   = 0;

   logic [7:0]  ta  [8][8];
   logic [7:0]  tbm [8][8];
   logic [15:0] tc  [8][8];

   logic [63:0] src[$];
   logic [63:0] got[$];
   logic [15:0] wlog[$];
   logic [63:0] exp_w[16];
   int src_idx, wr_cnt, start_cnt, done_cnt;

   always #5 clk = ~clk;

   tpu_host_seq #(
      .BITS_AB(8), .BITS_C(16), .DIM(8), .ADDRW(16), .DATAW(64), .MM_CYCLES(24)
   ) dut (
      .clk(clk), .rst(rst), .go(go), .load_c(load_c),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done),
      .bus_addr(bus_addr), .bus_r_w(bus_r_w), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
   );

   // TPU read port: C row r half h at 0x0300+16r+8h
   always_comb begin
      bus_rdata = '0;
      if (bus_addr[15:8] == 8'h03)
         bus_rdata = {tc[bus_addr[6:4]][{bus_addr[3], 2'b11}], tc[bus_addr[6:4]][{bus_addr[3], 2'b10}],
                      tc[bus_addr[6:4]][{bus_addr[3], 2'b01}], tc[bus_addr[6:4]][{bus_addr[3], 2'b00}]};
   end

   task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
      total++;
      if (got_v !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [63:0] d);
      logic [15:0] acc;
      if (a == 16'h0400) begin
         start_cnt++;
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
               acc = tc[3'(i)][3'(j)];
               for (int k = 0; k < 8; k++)
                  acc = acc + 16'(ta[3'(i)][3'(k)]) * 16'(tbm[3'(k)][3'(j)]);
               tc[3'(i)][3'(j)] = acc;
            end
      end else begin
         wr_cnt++;
         wlog.push_back(a);
         case (a[15:8])
            8'h01: for (int c = 0; c < 8; c++) ta[a[5:3]][3'(c)]  = d[8*c +: 8];
            8'h02: for (int c = 0; c < 8; c++) tbm[a[5:3]][3'(c)] = d[8*c +: 8];
            8'h03: for (int e = 0; e < 4; e++) tc[a[6:4]][{a[3], 2'(e)}] = d[16*e +: 16];
            default: ;
         endcase
      end
   endtask

   // A = identity, B[r][c] = r*8+c; expected C out equals B widened to 16 bits
   task automatic load_ident_b();
      logic [63:0] w;
      src.delete();
      for (int r = 0; r < 8; r++) src.push_back(64'h1 << (8 * r));
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) w[8*c +: 8] = 8'(r * 8 + c);
         src.push_back(w);
      end
      for (int i = 0; i < 16; i++)
         for (int e = 0; e < 4; e++) exp_w[i][16*e +: 16] = 16'((i / 2) * 8 + (i % 2) * 4 + e);
   endtask

   // A = B = all ones, C init all 1 -> every element 1 + 8 = 9
   task automatic load_ones();
      src.delete();
      for (int i = 0; i < 16; i++) src.push_back(64'h0101_0101_0101_0101);
      for (int i = 0; i < 16; i++) src.push_back(64'h0001_0001_0001_0001);
      for (int i = 0; i < 16; i++) exp_w[i] = 64'h0009_0009_0009_0009;
   endtask

   task automatic run_job(input bit lc, input bit toggle, input int stall_word,
                          input bit extra_go, input int abort_after);
      int cyc = 0;
      int start_cyc = -1;
      int stall_left = 5;
      int post_wr;
      bit phase = 1'b0;
      bit seen_done = 1'b0;
      src_idx = 0; wr_cnt = 0; start_cnt = 0; done_cnt = 0;
      got.delete(); wlog.delete();
      while (!seen_done && cyc < 400) begin
         @(negedge clk);
         go     = (cyc == 0) || (extra_go && (cyc == 20 || cyc == 45 || cyc == 60));
         load_c = lc;
         if (src_idx < src.size() && !(toggle && phase)) begin
            in_valid = 1'b1; in_data = src[src_idx];
         end else begin
            in_valid = 1'b0; in_data = '0;
         end
         out_ready = !(got.size() == stall_word && stall_left > 0);
         #1;
         if (bus_r_w) bus_write(bus_addr, bus_wdata);
         if (in_valid && in_ready) src_idx++;
         if (out_valid && !out_ready) begin
            check("stall_addr", 64'(bus_addr), 64'(16'h0300 + 16'(8 * stall_word)));
            check("stall_data", out_data, exp_w[stall_word]);
            stall_left--;
         end
         if (out_valid && out_ready) got.push_back(out_data);
         if (done) begin done_cnt++; seen_done = 1'b1; end
         if (start_cyc < 0 && start_cnt > 0) start_cyc = cyc;
         if (abort_after >= 0 && start_cyc >= 0 && cyc == start_cyc + abort_after) begin
            @(negedge clk);
            rst = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = '0;
            #1;
            if (bus_r_w) bus_write(bus_addr, bus_wdata);
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_r_w", 64'(bus_r_w), 64'd0);
            check("rst_addr", 64'(bus_addr), 64'd0);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            post_wr = wr_cnt + start_cnt;
            for (int t = 0; t < 4; t++) begin
               @(negedge clk); #1;
               if (bus_r_w) bus_write(bus_addr, bus_wdata);
            end
            check("rst_no_writes", 64'(wr_cnt + start_cnt), 64'(post_wr));
            return;
         end
         phase = !phase;
         cyc++;
      end
      go = 1'b0;
      check("done_seen", 64'(seen_done), 64'd1);
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
         #1;
         if (bus_r_w) bus_write(bus_addr, bus_wdata);
         if (done) done_cnt++;
         check("idle_busy", 64'(busy), 64'd0);
      end
   endtask

   task automatic check_results(input string tag);
      check({tag, "_words"}, 64'(got.size()), 64'd16);
      for (int i = 0; i < 16; i++)
         check({tag, "_c"}, (i < got.size()) ? got[i] : 64'hx, exp_w[i]);
      check({tag, "_starts"}, 64'(start_cnt), 64'd1);
      check({tag, "_done"}, 64'(done_cnt), 64'd1);
      check({tag, "_writes"}, 64'(wr_cnt), 64'd32);
   endtask

   initial begin
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            ta[i][j] = '0; tbm[i][j] = '0; tc[i][j] = '0;
         end
      rst = 1'b1; go = 1'b0; load_c = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_r_w", 64'(bus_r_w), 64'd0);
      check("rst_addr", 64'(bus_addr), 64'd0);
      check("rst_wdata", bus_wdata, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      load_ident_b();
      run_job(1'b0, 1'b0, -1, 1'b0, -1);
      check_results("ident");

      load_ones();
      run_job(1'b1, 1'b0, -1, 1'b0, -1);
      check_results("ones");

      load_ident_b();
      run_job(1'b0, 1'b1, -1, 1'b0, -1);
      check_results("toggle");
      for (int i = 0; i < 32; i++) begin
         logic [15:0] ea;
         if (i < 8)       ea = 16'h0100 + 16'(8 * i);
         else if (i < 16) ea = 16'h0200 + 16'(8 * (i - 8));
         else             ea = 16'h0300 + 16'(8 * (i - 16));
         check("toggle_addr", (i < wlog.size()) ? 64'(wlog[i]) : 64'hx, 64'(ea));
      end

      load_ident_b();
      run_job(1'b0, 1'b0, 3, 1'b0, -1);
      check_results("stall");

      load_ones();
      run_job(1'b1, 1'b0, -1, 1'b0, 3);
      load_ones();
      run_job(1'b1, 1'b0, -1, 1'b1, -1);
      check_results("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
